// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with registered one-hot and binary grant outputs.
// A grant is held until accepted; an accept with pending requests reloads with no bubble.
module rr_grant_encoder #(
   parameter int    NUM_REQUESTERS = 4,
   parameter string DIRECTION      = "LSB0",
   parameter int    INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic                      grant_ready,
   output logic                      grant_valid,
   output logic [NUM_REQUESTERS-1:0] grant_oh,
   output logic [INDEX_WIDTH-1:0]    grant_idx
);
   localparam int N    = NUM_REQUESTERS;
   localparam bit MSB0 = (DIRECTION == "MSB0");

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic [INDEX_WIDTH-1:0] pos_q, pos_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [N-1:0]           oh_q, oh_d;

   logic [INDEX_WIDTH-1:0] next_ptr, start;
   logic [N-1:0]           mask, masked, pick, sel_oh;
   logic [INDEX_WIDTH-1:0] pos_enc [N];
   logic [INDEX_WIDTH-1:0] idx_enc [N];
   logic [INDEX_WIDTH-1:0] sel_pos, sel_idx;

   // Position following the current grant; in HOLD this is where the next search starts.
   assign next_ptr = (pos_q == INDEX_WIDTH'(N-1)) ? '0 : pos_q + INDEX_WIDTH'(1);
   assign start    = (state_q == HOLD) ? next_ptr : ptr_q;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
         assign mask[gi]    = (INDEX_WIDTH'(gi) >= start);
         assign pos_enc[gi] = sel_oh[gi] ? INDEX_WIDTH'(gi) : '0;
         assign idx_enc[gi] = sel_oh[gi] ? INDEX_WIDTH'(MSB0 ? (N-1-gi) : gi) : '0;
      end
   endgenerate

   // Search from start upward; if nothing there, wrap to the lowest set bit overall.
   assign masked = request & mask;
   assign pick   = (|masked) ? masked : request;
   assign sel_oh = pick & (~pick + N'(1));

   always_comb begin
      sel_pos = '0;
      sel_idx = '0;
      for (int i = 0; i < N; i++) begin
         sel_pos = sel_pos | pos_enc[i];
         sel_idx = sel_idx | idx_enc[i];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pos_d   = pos_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      case (state_q)
         IDLE: begin
            if (|request) begin
               state_d = HOLD;
               oh_d    = sel_oh;
               idx_d   = sel_idx;
               pos_d   = sel_pos;
            end
         end
         HOLD: begin
            if (grant_ready) begin
               ptr_d = next_ptr;
               if (|request) begin
                  oh_d  = sel_oh;
                  idx_d = sel_idx;
                  pos_d = sel_pos;
               end else begin
                  state_d = IDLE;
                  oh_d    = '0;
                  idx_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         pos_q   <= '0;
         idx_q   <= '0;
         oh_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pos_q   <= pos_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
      end
   end

   assign grant_valid = (state_q == HOLD);
   assign grant_oh    = oh_q;
   assign grant_idx   = idx_q;

endmodule

// File: doc/rr_grant_encoder.md
RR_GRANT_ENCODER -- requirements
Module: rr_grant_encoder

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of request lines; legal range 2..64.
REQ-002 SHALL have parameter DIRECTION, default "LSB0", index encoding: "LSB0" index = bit position, "MSB0" index = NUM_REQUESTERS-1-bit position.
REQ-003 SHALL have parameter INDEX_WIDTH, default $clog2(NUM_REQUESTERS), width of grant_idx.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port request  input  NUM_REQUESTERS  per-requester request levels, any number set.
REQ-007 SHALL have port grant_ready  input  1  consumer accepts current grant this cycle.
REQ-008 SHALL have port grant_valid  output  1  registered; grant_oh/grant_idx hold a valid grant.
REQ-009 SHALL have port grant_oh  output  NUM_REQUESTERS  registered one-hot grant, bit = granted position.
REQ-010 SHALL have port grant_idx  output  INDEX_WIDTH  registered binary index of grant per DIRECTION.

Function
REQ-011 SHALL keep internal priority pointer ptr (INDEX_WIDTH bits, range 0..NUM_REQUESTERS-1), always a bit position regardless of DIRECTION.
REQ-012 SHALL operate two states: IDLE (grant_valid=0) and HOLD (grant_valid=1).
REQ-013 SHALL select, when loading, the first set request bit searching positions start, start+1, ... wrapping NUM_REQUESTERS-1 -> 0.
REQ-014 SHALL in IDLE with request != 0: load grant at next edge (one-cycle latency), start = ptr, enter HOLD.
REQ-015 SHALL in IDLE with request == 0: remain IDLE, outputs grant_oh=0, grant_idx=0.
REQ-016 SHALL in HOLD with grant_ready=0: keep grant_valid, grant_oh, grant_idx, ptr unchanged regardless of request changes, including withdrawal of granted request.
REQ-017 SHALL in HOLD with grant_ready=1 (accept): set ptr = (granted position+1) mod NUM_REQUESTERS.
REQ-018 SHALL on accept with request != 0 same cycle: load new grant at same edge with start = (granted position+1) mod NUM_REQUESTERS, stay HOLD (back-to-back, no bubble).
REQ-019 SHALL on accept with request == 0: enter IDLE, grant_oh=0, grant_idx=0.
REQ-020 SHALL allow re-grant of same requester on back-to-back accept only if it is the sole requester.
REQ-021 SHALL ignore grant_ready in IDLE.
REQ-022 SHALL guarantee grant_oh has exactly one bit set whenever grant_valid=1, and grant_idx consistent with grant_oh per DIRECTION.
REQ-023 SHALL compute grant_idx by OR-reduction of per-bit encoded indices (no priority chain on the one-hot to index path).
REQ-024 SHALL give every requester continuously asserted a grant within NUM_REQUESTERS accepted grants.

Reset
REQ-025 SHALL on reset assertion immediately (asynchronously) force grant_valid=0, grant_oh=0, grant_idx=0, ptr=0, state IDLE.
REQ-026 SHALL on reset mid-HOLD discard pending grant; after deassertion behave as from power-up.
REQ-027 SHALL make first grant after reset evaluate request with start = 0.

Verification
REQ-028 Reset with request=4'b0000 for 5 cycles -> grant_valid=0, grant_oh=0, grant_idx=0 throughout.
REQ-029 N=4 LSB0, request=4'b1010, grant_ready=1 constant -> grants pos1 (idx1), pos3 (idx3), pos1, pos3, no idle cycles.
REQ-030 Grant pos2 held, grant_ready=0 3 cycles, request changes to 4'b0001 -> grant_oh=4'b0100, grant_idx=2 stable; accept -> next grant pos0.
REQ-031 N=4 MSB0, request=4'b0001 -> grant_oh=4'b0001, grant_idx=3; request=4'b1000 -> grant_idx=0.
REQ-032 Wrap: accept grant pos3 with request=4'b1001 -> next grant pos0, ptr=1 after its accept.
REQ-033 Reset pulse while grant_valid=1 -> outputs 0 same cycle; after release request=4'b0110 -> grant pos1.
